// File: rtl/tpu_seq_ctrl_if.sv
// Host/FIFO/SRAM side signal bundle for the tile-multiply sequencer.
// Latency: n/a (wires only).
// Backpressure: none; the FIFO empty flag is only consulted when a start is sampled.
interface tpu_seq_ctrl_if #(
    parameter int ADDRESSSIZE = 10
);
    logic                   start;
    logic                   abort;
    logic [ADDRESSSIZE-1:0] act_base;
    logic [ADDRESSSIZE-1:0] res_base;
    logic                   fifo_empty;
    logic                   fifo_read_enable;
    logic                   we_rl;
    logic                   valid_address;
    logic [ADDRESSSIZE-1:0] act_addr;
    logic                   res_we;
    logic [ADDRESSSIZE-1:0] res_addr;
    logic                   busy;
    logic                   end_;
    logic                   err_empty;

    modport slave (
        input  start, abort, act_base, res_base, fifo_empty,
        output fifo_read_enable, we_rl, valid_address, act_addr,
               res_we, res_addr, busy, end_, err_empty
    );

    modport master (
        output start, abort, act_base, res_base, fifo_empty,
        input  fifo_read_enable, we_rl, valid_address, act_addr,
               res_we, res_addr, busy, end_, err_empty
    );
endinterface

// File: rtl/tpu_seq_ctrl.sv
// Sequences one tile multiply: weight pop, weight latch, activation feed, drain, result write.
// Latency: end_ pulses in the cycle after edge 3+2*MATRIX_SIZE+DRAIN_LAT, counting the start edge as 0.
// Backpressure: none; start is taken only in IDLE, abort cancels any operation at once.
module tpu_seq_ctrl #(
    parameter int ADDRESSSIZE = 10,
    parameter int MATRIX_SIZE = 32,
    parameter int DRAIN_LAT   = 64
) (
    input  logic           clk,
    input  logic           rstn,
    tpu_seq_ctrl_if.slave  bus
);
    localparam int MAXC = (MATRIX_SIZE > DRAIN_LAT) ? MATRIX_SIZE : DRAIN_LAT;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        IDLE, WLOAD, WLATCH, FEED, DRAIN, WRITE, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ADDRESSSIZE-1:0] act_base_q, act_base_d;
    logic [ADDRESSSIZE-1:0] res_base_q, res_base_d;
    logic [ADDRESSSIZE-1:0] act_addr_q, act_addr_d;
    logic [ADDRESSSIZE-1:0] res_addr_q, res_addr_d;
    logic                   end_q, end_d;
    logic                   err_q, err_d;

    always_comb begin
        state_d    = state_q;
        act_base_d = act_base_q;
        res_base_d = res_base_q;
        end_d      = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.fifo_empty) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = WLOAD;
                        act_base_d = bus.act_base;
                        res_base_d = bus.res_base;
                    end
                end
            end
            WLOAD:   state_d = WLATCH;
            WLATCH:  state_d = FEED;
            FEED:    if (cnt_q == CW'(MATRIX_SIZE - 1)) state_d = DRAIN;
            DRAIN:   if (cnt_q == CW'(DRAIN_LAT - 1))   state_d = WRITE;
            WRITE:   if (cnt_q == CW'(MATRIX_SIZE - 1)) state_d = DONE;
            DONE: begin
                state_d = IDLE;
                end_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Abort outranks every exit, including DONE, and suppresses the completion pulse.
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            end_d   = 1'b0;
        end

        if ((state_d == state_q) && (state_q inside {FEED, DRAIN, WRITE})) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end

        // Addresses track the next cycle's counter so they line up with the decoded strobes.
        act_addr_d = act_addr_q;
        if (state_d == FEED) begin
            act_addr_d = act_base_q + ADDRESSSIZE'(cnt_d);
        end
        res_addr_d = res_addr_q;
        if (state_d == WRITE) begin
            res_addr_d = res_base_q + ADDRESSSIZE'(cnt_d);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            act_base_q <= '0;
            res_base_q <= '0;
            act_addr_q <= '0;
            res_addr_q <= '0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_base_q <= act_base_d;
            res_base_q <= res_base_d;
            act_addr_q <= act_addr_d;
            res_addr_q <= res_addr_d;
            end_q      <= end_d;
            err_q      <= err_d;
        end
    end

    assign bus.fifo_read_enable = (state_q == WLOAD);
    assign bus.we_rl            = (state_q == WLATCH);
    assign bus.valid_address    = (state_q == FEED);
    assign bus.res_we           = (state_q == WRITE);
    assign bus.busy             = (state_q != IDLE);
    assign bus.act_addr         = act_addr_q;
    assign bus.res_addr         = res_addr_q;
    assign bus.end_             = end_q;
    assign bus.err_empty        = err_q;
endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboarded directed bench for tpu_seq_ctrl: nominal, wrap, empty FIFO, aborts, reset, back-to-back.
module tb_tpu_seq_ctrl;
    localparam int AW = 10;
    localparam int M  = 32;
    localparam int D  = 64;

    typedef struct {
        int kind;   // 0 fifo_read_enable, 1 we_rl, 2 valid_address, 3 res_we, 4 end_, 5 err_empty
        int addr;
        int stamp;
    } ev_t;

    logic clk;
    logic rstn;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];

    tpu_seq_ctrl_if #(.ADDRESSSIZE(AW)) bif();

    tpu_seq_ctrl #(
        .ADDRESSSIZE(AW),
        .MATRIX_SIZE(M),
        .DRAIN_LAT(D)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int addr, input int stamp);
        ev_t e;
        e.kind  = kind;
        e.addr  = addr;
        e.stamp = stamp;
        exp_q.push_back(e);
    endtask

    // Expected strobe train for one operation whose start is sampled at edge e0.
    task automatic push_run(input int e0, input int ab, input int rb,
                            input int n_va, input int n_we, input bit with_end);
        push_ev(0, 0, e0);
        push_ev(1, 0, e0 + 1);
        for (int k = 0; k < n_va; k++) push_ev(2, (ab + k) % 1024, e0 + 2 + k);
        for (int k = 0; k < n_we; k++) push_ev(3, (rb + k) % 1024, e0 + 2 + M + D + k);
        if (with_end) push_ev(4, 0, e0 + 3 + 2 * M + D);
    endtask

    task automatic pop_cmp(input int kind, input int addr);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind=%0d addr=%0d at cycle %0d, expected no event",
                     kind, addr, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.stamp != cyc) begin
                n_fail++;
                $display("FAIL sb_event: got kind=%0d addr=%0d cycle=%0d, expected kind=%0d addr=%0d cycle=%0d",
                         kind, addr, cyc, e.kind, e.addr, e.stamp);
            end
        end
    endtask

    // Monitor: every strobe the DUT shows is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (bif.fifo_read_enable) pop_cmp(0, 0);
        if (bif.we_rl)            pop_cmp(1, 0);
        if (bif.valid_address)    pop_cmp(2, int'(bif.act_addr));
        if (bif.res_we)           pop_cmp(3, int'(bif.res_addr));
        if (bif.end_)             pop_cmp(4, 0);
        if (bif.err_empty)        pop_cmp(5, 0);
    end

    task automatic wait_stamp(input int s);
        while (cyc < s) @(negedge clk);
    endtask

    task automatic start_op(input int ab, input int rb, output int e0);
        bif.start    = 1'b1;
        bif.act_base = AW'(ab);
        bif.res_base = AW'(rb);
        e0 = cyc + 1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int e1;
        rstn           = 1'b0;
        bif.start      = 1'b0;
        bif.abort      = 1'b0;
        bif.act_base   = '0;
        bif.res_base   = '0;
        bif.fifo_empty = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({bif.fifo_read_enable, bif.we_rl, bif.valid_address, bif.res_we,
                    bif.busy, bif.end_, bif.err_empty, bif.act_addr, bif.res_addr}), 0);

        // Nominal run, start presented on the very first edge after reset release.
        rstn = 1'b1;
        start_op(0, 0, e0);
        push_run(e0, 0, 0, M, M, 1'b1);
        @(negedge clk);
        bif.start = 1'b0;
        check("busy_in_wload", int'(bif.busy), 1);
        wait_stamp(e0 + 50);
        bif.start = 1'b1;           // must be ignored while busy
        @(negedge clk);
        bif.start = 1'b0;
        wait_stamp(e0 + 132);
        check("nominal_idle", int'(bif.busy), 0);
        check("nominal_act_hold", int'(bif.act_addr), 31);
        check("nominal_res_hold", int'(bif.res_addr), 31);

        // Address wrap; bases and fifo_empty change after acceptance without effect.
        @(negedge clk);
        start_op(1020, 1000, e0);
        push_run(e0, 1020, 1000, M, M, 1'b1);
        @(negedge clk);
        bif.start      = 1'b0;
        bif.fifo_empty = 1'b1;
        bif.act_base   = AW'(5);
        bif.res_base   = AW'(6);
        wait_stamp(e0 + 133);
        bif.fifo_empty = 1'b0;
        check("wrap_act_hold", int'(bif.act_addr), 27);
        check("wrap_res_hold", int'(bif.res_addr), 7);

        // Start against an empty FIFO.
        bif.fifo_empty = 1'b1;
        start_op(0, 0, e0);
        push_ev(5, 0, e0);
        @(negedge clk);
        bif.start = 1'b0;
        check("empty_busy", int'(bif.busy), 0);
        @(negedge clk);
        check("empty_err_one_cycle", int'(bif.err_empty), 0);
        bif.fifo_empty = 1'b0;
        repeat (3) @(negedge clk);
        check("empty_still_idle", int'(bif.busy), 0);

        // Abort at FEED k=10, then abort+start together in IDLE, then a full run.
        start_op(100, 200, e0);
        push_run(e0, 100, 200, 11, 0, 1'b0);
        @(negedge clk);
        bif.start = 1'b0;
        wait_stamp(e0 + 12);
        bif.abort = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
        check("abort_valid_low", int'(bif.valid_address), 0);
        check("abort_busy_low", int'(bif.busy), 0);
        bif.abort = 1'b1;
        bif.start = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
        bif.start = 1'b0;
        check("abort_idle_start_ignored", int'(bif.busy), 0);
        start_op(3, 4, e0);
        push_run(e0, 3, 4, M, M, 1'b1);
        @(negedge clk);
        bif.start = 1'b0;
        wait_stamp(e0 + 133);
        check("post_abort_idle", int'(bif.busy), 0);

        // Abort while in DONE: no completion pulse.
        start_op(0, 0, e0);
        push_run(e0, 0, 0, M, M, 1'b0);
        @(negedge clk);
        bif.start = 1'b0;
        wait_stamp(e0 + 130);
        check("done_busy", int'(bif.busy), 1);
        bif.abort = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
        check("done_abort_busy", int'(bif.busy), 0);
        check("done_abort_no_end", int'(bif.end_), 0);
        repeat (3) @(negedge clk);

        // Reset during DRAIN.
        start_op(50, 60, e0);
        push_run(e0, 50, 60, M, 0, 1'b0);
        @(negedge clk);
        bif.start = 1'b0;
        wait_stamp(e0 + 40);
        rstn = 1'b0;
        #1;
        check("reset_mid_outputs",
              int'({bif.fifo_read_enable, bif.we_rl, bif.valid_address, bif.res_we,
                    bif.busy, bif.end_, bif.err_empty, bif.act_addr, bif.res_addr}), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (140) @(negedge clk);
        check("reset_no_restart", int'(bif.busy), 0);

        // Back-to-back with start held high.
        start_op(10, 20, e0);
        e1 = e0 + 132;
        push_run(e0, 10, 20, M, M, 1'b1);
        push_run(e1, 10, 20, M, M, 1'b1);
        wait_stamp(e1 + 60);
        bif.start = 1'b0;
        wait_stamp(e1 + 135);
        check("b2b_idle", int'(bif.busy), 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
